// File: rtl/sparrow_pkg.sv
// Shared SPARROW types: lane component, multiply-reduce op encoding,
// per-beat control and result flag structs, 16-bit clamp limits.
package sparrow;

   typedef logic [15:0] high_prec_component;

   typedef enum logic [1:0] {
      MR_SUM = 2'd0,
      MR_MAX = 2'd1,
      MR_MIN = 2'd2,
      MR_RSV = 2'd3
   } mulred_op_type;

   typedef struct packed {
      mulred_op_type op;
      logic          sign;
      logic          sat;
      logic          acc_en;
      logic          acc_clr;
   } mulred_in_type;

   typedef struct packed {
      logic sum_ovf;
      logic clamped;
   } mulred_out_type;

   localparam high_prec_component S16MAX = 16'h7FFF;
   localparam high_prec_component S16MIN = 16'h8000;
   localparam high_prec_component U16MAX = 16'hFFFF;

endpackage

// File: rtl/mulred_acc_tree.sv
// Combinational log2(NLANES)-level reduction of the product lanes by
// SUM/MAX/MIN after extension to ACC_W; the reserved op reduces to zero.
module mulred_tree
   import sparrow::*;
#(
   parameter int NLANES = 4,
   parameter int ACC_W  = 24
) (
   input  logic [NLANES*16-1:0] prod,
   input  logic [1:0]           op,
   input  logic                 sign,
   output logic [ACC_W-1:0]     red
);

   localparam int LVLS = $clog2(NLANES);

   logic [ACC_W-1:0]   lvl [LVLS+1][NLANES];
   high_prec_component lane;
   mulred_op_type      op_e;

   function automatic logic [ACC_W-1:0] pick(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b,
                                             input mulred_op_type    o,
                                             input logic             s);
      logic a_gt;
      a_gt = s ? ($signed(a) > $signed(b)) : (a > b);
      case (o)
         MR_SUM:  return a + b;
         MR_MAX:  return a_gt ? a : b;
         MR_MIN:  return a_gt ? b : a;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      op_e = mulred_op_type'(op);
      lane = '0;
      for (int l = 0; l <= LVLS; l++)
         for (int i = 0; i < NLANES; i++)
            lvl[l][i] = '0;
      for (int i = 0; i < NLANES; i++) begin
         lane = prod[16*i +: 16];
         lvl[0][i] = sign ? {{(ACC_W-16){lane[15]}}, lane} : {{(ACC_W-16){1'b0}}, lane};
      end
      // ACC_W leaves headroom for log2(NLANES) carries, so the SUM tree never wraps
      for (int l = 0; l < LVLS; l++)
         for (int i = 0; i < (NLANES >> (l+1)); i++)
            lvl[l+1][i] = pick(lvl[l][2*i], lvl[l][2*i+1], op_e, sign);
      red = (op_e == MR_RSV) ? '0 : lvl[LVLS][0];
   end

endmodule

// File: rtl/mulred_acc.sv
// Two-stage reduce/accumulate pipeline with optional 16-bit saturation.
// SPARROW_MULRED_OVF_EN adds a sticky ovf output (sum overflow or clamp).
module mulred_acc
   import sparrow::*;
#(
   parameter int NLANES = 4,
   parameter int ACC_W  = 24
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NLANES*16-1:0] prod,
   input  logic [1:0]           op,
   input  logic                 sign,
   input  logic                 sat,
   input  logic                 acc_en,
   input  logic                 acc_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_W-1:0]     out_res
`ifdef SPARROW_MULRED_OVF_EN
   ,
   output logic                 ovf
`endif
);

   localparam logic [ACC_W-1:0] SMAX_W = {{(ACC_W-16){1'b0}}, S16MAX};
   localparam logic [ACC_W-1:0] SMIN_W = {{(ACC_W-16){1'b1}}, S16MIN};
   localparam logic [ACC_W-1:0] UMAX_W = {{(ACC_W-16){1'b0}}, U16MAX};

   logic                 s1_valid_q, s1_valid_d;
   logic [ACC_W-1:0]     s1_red_q,   s1_red_d;
   mulred_in_type        s1_ctl_q,   s1_ctl_d;
   logic                 out_valid_q, out_valid_d;
   logic [ACC_W-1:0]     out_res_q,  out_res_d;
   logic [ACC_W-1:0]     acc_q,      acc_d;

   logic [ACC_W-1:0]     red, comb_val, new_val, sat_val;
   logic                 s2_load, acc_gt, do_acc;

   mulred_tree #(.NLANES(NLANES), .ACC_W(ACC_W)) u_tree (
      .prod (prod),
      .op   (op),
      .sign (sign),
      .red  (red)
   );

   always_comb begin
      s2_load    = s1_valid_q && (!out_valid_q || out_ready);
      in_ready   = !s1_valid_q || s2_load;
      s1_valid_d = in_ready ? in_valid : s1_valid_q;
      s1_red_d   = s1_red_q;
      s1_ctl_d   = s1_ctl_q;
      if (in_valid && in_ready) begin
         s1_red_d         = red;
         s1_ctl_d.op      = mulred_op_type'(op);
         s1_ctl_d.sign    = sign;
         s1_ctl_d.sat     = sat;
         s1_ctl_d.acc_en  = acc_en;
         s1_ctl_d.acc_clr = acc_clr;
      end

      acc_gt = s1_ctl_q.sign ? ($signed(acc_q) > $signed(s1_red_q)) : (acc_q > s1_red_q);
      case (s1_ctl_q.op)
         MR_SUM:  comb_val = acc_q + s1_red_q;
         MR_MAX:  comb_val = acc_gt ? acc_q : s1_red_q;
         MR_MIN:  comb_val = acc_gt ? s1_red_q : acc_q;
         default: comb_val = acc_q;
      endcase
      do_acc  = s1_ctl_q.acc_en && !s1_ctl_q.acc_clr;
      new_val = do_acc ? comb_val : s1_red_q;

      sat_val = new_val;
      if (s1_ctl_q.sat) begin
         if (s1_ctl_q.sign) begin
            if ($signed(new_val) > $signed(SMAX_W))
               sat_val = SMAX_W;
            else if ($signed(new_val) < $signed(SMIN_W))
               sat_val = SMIN_W;
         end else if (new_val > UMAX_W) begin
            sat_val = UMAX_W;
         end
      end

      out_valid_d = s2_load || (out_valid_q && !out_ready);
      out_res_d   = s2_load ? sat_val : out_res_q;
      // accumulator keeps the unsaturated value; plain (non-acc) beats leave it alone
      acc_d       = (s2_load && (s1_ctl_q.acc_clr || s1_ctl_q.acc_en)) ? new_val : acc_q;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_valid_q  <= 1'b0;
         s1_red_q    <= '0;
         s1_ctl_q    <= '0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
         acc_q       <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_red_q    <= s1_red_d;
         s1_ctl_q    <= s1_ctl_d;
         out_valid_q <= out_valid_d;
         out_res_q   <= out_res_d;
         acc_q       <= acc_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_res   = out_res_q;

`ifdef SPARROW_MULRED_OVF_EN
   logic [ACC_W:0]  sum_ext;
   mulred_out_type  flags;
   logic            ovf_q, ovf_d;

   always_comb begin
      sum_ext       = {1'b0, acc_q} + {1'b0, s1_red_q};
      flags.sum_ovf = 1'b0;
      if (do_acc && (s1_ctl_q.op == MR_SUM))
         flags.sum_ovf = s1_ctl_q.sign
            ? ((acc_q[ACC_W-1] == s1_red_q[ACC_W-1]) && (sum_ext[ACC_W-1] != acc_q[ACC_W-1]))
            : sum_ext[ACC_W];
      flags.clamped = (sat_val != new_val);
      ovf_d = ovf_q;
      // a clearing beat drops the old flag but may raise it again itself
      if (s2_load)
         ovf_d = (ovf_q && !s1_ctl_q.acc_clr) || flags.sum_ovf || flags.clamped;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mulred_acc.sv
// Directed-vector bench for mulred_acc with hand-computed expected results.
module tb_mulred_acc;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] prod;
   logic [1:0]  op;
   logic        sign, sat, acc_en, acc_clr;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_res;
`ifdef SPARROW_MULRED_OVF_EN
   logic        ovf;
`endif

   int n_vec = 0;
   int n_err = 0;
   logic [23:0] got_q[$];

   always #5 clk = ~clk;

   mulred_acc #(.NLANES(4), .ACC_W(24)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .prod      (prod),
      .op        (op),
      .sign      (sign),
      .sat       (sat),
      .acc_en    (acc_en),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res)
`ifdef SPARROW_MULRED_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   // results consumed at the next rising edge
   always @(negedge clk)
      if (rstn && out_valid && out_ready) got_q.push_back(out_res);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // called just after a rising edge; returns just after the accepting edge
   task automatic send(input logic [63:0] p, input logic [1:0] o, input logic s,
                       input logic sa, input logic en, input logic clr);
      bit ok;
      ok = 0;
      prod = p; op = o; sign = s; sat = sa; acc_en = en; acc_clr = clr;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!ok) check("send_stall", 32'd0, 32'd1);
   endtask

   task automatic expect_res(input string tag, input logic [23:0] exp);
      for (int i = 0; i < 20 && got_q.size() == 0; i++) @(posedge clk);
      #1;
      check({tag, "_cnt"}, got_q.size(), 1);
      if (got_q.size() > 0) check(tag, got_q.pop_front(), exp);
      got_q.delete();
   endtask

   localparam logic [63:0] ONES = {16'h0001, 16'h0001, 16'h0001, 16'h0001};
   localparam logic [63:0] MIX  = {16'hFF80, 16'h0010, 16'h8000, 16'h0005};
   localparam logic [63:0] Q4K  = {16'h4000, 16'h4000, 16'h4000, 16'h4000};

   initial begin
      rstn = 1'b0; in_valid = 1'b0; prod = '0; op = 2'd0;
      sign = 1'b0; sat = 1'b0; acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
      #13;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_res", out_res, 0);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;

      // latency: handshake at edge A, out_valid after edge A+1
      prod = {16'h0001, 16'h0002, 16'h0003, 16'h0004}; op = 2'd0;
      sign = 0; sat = 0; acc_en = 0; acc_clr = 1; in_valid = 1;
      @(posedge clk); #1;
      in_valid = 0;
      check("lat_c1_valid", out_valid, 0);
      @(posedge clk); #1;
      check("lat_c2_valid", out_valid, 1);
      check("sum_u", out_res, 24'h00000A);
      @(negedge clk); @(posedge clk); #1;
      got_q.delete();

      send(MIX, 2'd1, 1, 0, 0, 0); expect_res("max_s", 24'h000010);
      send(MIX, 2'd2, 1, 0, 0, 0); expect_res("min_s", 24'hFF8000);
      send(MIX, 2'd1, 0, 0, 0, 0); expect_res("max_u", 24'h00FF80);
      send(MIX, 2'd2, 0, 0, 0, 0); expect_res("min_u", 24'h000005);
      send({4{16'hFFFF}}, 2'd0, 1, 0, 0, 0); expect_res("sum_s_neg", 24'hFFFFFC);

      // accumulate then saturate
      send(Q4K, 2'd0, 0, 0, 0, 1); expect_res("acc_b1", 24'h010000);
`ifdef SPARROW_MULRED_OVF_EN
      check("ovf_b1", ovf, 0);
`endif
      send(Q4K, 2'd0, 0, 1, 1, 0); expect_res("acc_b2_sat", 24'h00FFFF);
`ifdef SPARROW_MULRED_OVF_EN
      check("ovf_b2", ovf, 1);
`endif
      send('0, 2'd0, 0, 0, 1, 0); expect_res("acc_unsat", 24'h020000);
      send({4{16'h8000}}, 2'd0, 1, 1, 0, 1); expect_res("sat_s_neg", 24'hFF8000);
      send({4{16'hFFFF}}, 2'd0, 1, 1, 0, 1); expect_res("sat_s_none", 24'hFFFFFC);
`ifdef SPARROW_MULRED_OVF_EN
      check("ovf_clr", ovf, 0);
`endif

      // back-pressure
      got_q.delete();
      out_ready = 1'b0;
      fork
         begin
            send(ONES, 2'd0, 0, 0, 1, 1);
            send(ONES, 2'd0, 0, 0, 1, 0);
            send(ONES, 2'd0, 0, 0, 1, 0);
            send(ONES, 2'd0, 0, 0, 1, 0);
         end
         begin
            @(posedge clk); #2;
            check("bp_rdy_1", in_ready, 1);
            @(posedge clk); #2;
            check("bp_rdy_2", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_res_a", out_res, 24'd4);
            repeat (2) @(posedge clk);
            #2;
            check("bp_hold", out_res, 24'd4);
            check("bp_rdy_3", in_ready, 0);
            out_ready = 1'b1;
         end
      join
      for (int i = 0; i < 30 && got_q.size() < 4; i++) @(posedge clk);
      #1;
      check("bp_count", got_q.size(), 4);
      for (int i = 0; i < 4 && got_q.size() > 0; i++)
         check($sformatf("bp_seq%0d", i), got_q.pop_front(), 4*(i+1));
      got_q.delete();

      // reset with both stages full
      out_ready = 1'b0;
      send(ONES, 2'd0, 0, 0, 1, 1);
      send(ONES, 2'd0, 0, 0, 1, 0);
      check("pre_rst_ready", in_ready, 0);
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_res", out_res, 0);
      check("mid_rst_ready", in_ready, 1);
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      got_q.delete();
      send(ONES, 2'd0, 0, 0, 1, 0); expect_res("post_rst_acc", 24'd4);

      // reserved op reduces to zero
      send(ONES, 2'd3, 0, 0, 0, 0); expect_res("op_rsv", 24'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/mulred_acc.md
Name: mulred_acc

Overview:
- Downstream consumer of the per-lane low-precision multiplier outputs: takes one beat of NLANES 16-bit products.
- Reduces them to a scalar by SUM, MAX or MIN, then optionally accumulates across beats into a wide register.
- Returns the result, optionally saturated to 16 bits, through a 2-deep valid/ready pipeline.
- Feeds the SPARROW writeback/scalar result path.

Parameters:
- NLANES, 4, number of product lanes; power of 2, 2..8.
- ACC_W, 24, accumulator width in bits; must be >= 16+log2(NLANES)+1.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- prod  in  NLANES*16  products; lane i at [16i+15:16i].
- op  in  2  0=SUM, 1=MAX, 2=MIN, 3=reserved.
- sign  in  1  1 = products and accumulator are two's complement.
- sat  in  1  1 = saturate output to 16 bits.
- acc_en  in  1  combine the beat with the accumulator.
- acc_clr  in  1  restart the accumulator with this beat.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_res  out  ACC_W  result; sign/zero-extended when sat=1.

Behaviour:
- Reset (async, rstn=0): s1_valid=0, out_valid=0, acc=0, out_res=0. in_ready is combinational and equals 1 after reset.
- Stage 1:
  - On in_valid && in_ready, register the tree-reduced value together with op, sign, sat, acc_en and acc_clr.
  - Reduction tree:
    - Operands are extended to ACC_W: sign-extended if sign=1, else zero-extended.
    - SUM: full-width add, no wrap inside the tree.
    - MAX/MIN: compare as signed if sign=1, else unsigned.
    - op=3: reduced value = 0, and the beat is still processed.
- Stage 2:
  - Accumulator update:
    - If acc_clr=1: next acc = red. acc_clr has priority over acc_en.
    - Else if acc_en=1: next acc = acc OP red, using the same signedness rules. SUM wraps modulo 2^ACC_W.
    - Else: acc is unchanged, and the result is red alone.
  - Output:
    - out_res = the new accumulated or reduced value, with saturation applied when sat=1:
      - signed: clamp to [0xFFFF8000 sign-extended, 0x7FFF];
      - unsigned: clamp to 0xFFFF.
    - The accumulator always holds the unsaturated value.
- Latency: 2 cycles from input handshake to out_valid, when no back-pressure is applied.
- Handshake:
  - s2 loads when s1_valid && (!out_valid || out_ready).
  - in_ready = !s1_valid || s2 loads this cycle.
  - Full throughput of one beat per cycle.
  - out_res and out_valid hold stable while out_valid && !out_ready.
  - The accumulator updates only when s2 loads, so a stalled beat is never double-counted.
- Simultaneous events:
  - Output consumed and a new s1 beat in the same cycle: s2 reloads, with no bubble.
  - acc_clr and acc_en both 1: treated as a clear.
- Mode changes: op, sign and sat travel with each beat. Mixing ops while accumulating is legal, and the result is exactly what the combine rule defines.
- Reset mid-operation: all in-flight beats are dropped and acc=0.

Optional Feature:
- Macro: SPARROW_MULRED_OVF_EN.
- When defined, the block adds output ovf (1 bit), which is a sticky flag:
  - It is set when an accumulate SUM overflows ACC_W.
  - It is set when a saturation clamp is applied.
  - It is cleared on reset and on any acc_clr beat. The clear happens first, then that beat's event can set it again.
- When the macro is undefined, the port is absent and there is no extra logic.

Decomposition:
- Package sparrow gains:
  - mulred_op_type enum (MR_SUM, MR_MAX, MR_MIN, MR_RSV);
  - mulred_in_type and mulred_out_type structs;
  - constants S16MAX=0x7FFF, S16MIN=0x8000, U16MAX=0xFFFF.
- The existing high_prec_component type is reused for the lanes.
- Sub-module mulred_tree: purely combinational log2(NLANES)-level reduction, parameterised on NLANES and ACC_W.

Test Plan:
- Unsigned SUM, prod={0x0001,0x0002,0x0003,0x0004}, sign=0, sat=0, acc_clr=1 → out_res=0x00000A, 2 cycles after the handshake.
- Signed MAX, prod={0xFF80,0x0010,0x8000,0x0005}, sign=1 → out_res=0x000010. Same beat with MIN → 0xFF8000.
- Accumulate, then saturate:
  - Beat 1: acc_clr=1, SUM of 4×0x4000 → acc=0x010000.
  - Beat 2: acc_en=1, sat=1, sign=0, same products → out_res=0x00FFFF, acc=0x020000.
  - With SPARROW_MULRED_OVF_EN defined: ovf=1.
- Back-pressure: 4 back-to-back beats of SUM 1s with acc_en=1, out_ready low for 3 cycles:
  - in_ready falls after 2 accepted beats;
  - out_res holds stable;
  - final out_res values are 4, 8, 12, 16 in order, with no duplicates.
- Reset mid-stream: assert rstn=0 with both stages valid → out_valid=0, acc=0 immediately. The next beat with acc_en=1 and SUM 1s yields 4.
- op=3 with acc_en=0 → out_res=0, handshake completes normally.
